// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester bus plus shared-multiplier handshake for the arbiter
interface mult_share_arbiter_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0] req, done, err;
  logic [8*N_REQ-1:0] op_a, op_b;
  logic [15:0] result, m_result;
  logic [1:0] gnt_id;
  logic [7:0] m_a, m_b;
  logic busy, m_ld, m_rdy;
  modport slave(input req, op_a, op_b, m_rdy, m_result, output done, err, result, busy, gnt_id, m_ld, m_a, m_b);
  modport master(output req, op_a, op_b, m_rdy, m_result, input done, err, result, busy, gnt_id, m_ld, m_a, m_b);
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 8x8 multiplier among three requesters with timeout
module mult_share_arbiter #(
  parameter int N_REQ = 3,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  mult_share_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state, ptr, gnt, win, c1, c2;
  logic [7:0] cnt, a, b;
  logic [N_REQ-1:0] done, sel;
  logic [15:0] result;
  logic abort, timeout;
  always_comb begin
    c1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
    win = bus.req[ptr] ? ptr : bus.req[c1] ? c1 : c2;
    sel = N_REQ'(1) << gnt;
    timeout = cnt == 8'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= 2'd0;
      gnt <= 2'd3;
      cnt <= 8'd0;
      abort <= 1'b0;
      done <= '0;
      result <= 16'h0000;
      a <= 8'd0;
      b <= 8'd0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (|bus.req) begin
          state <= LOAD;
          gnt <= win;
          ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
          a <= bus.op_a[8*win +: 8];
          b <= bus.op_b[8*win +: 8];
        end
        LOAD: begin
          state <= WAIT;
          cnt <= 8'd0;
          abort <= 1'b0;
        end
        WAIT: if (bus.m_rdy || timeout) begin
          state <= DONE;
          result <= bus.m_rdy ? bus.m_result : 16'h0000;
          abort <= !bus.m_rdy;
          // a requester that withdrew before completion gets no pulse
          done <= sel & bus.req;
        end else cnt <= cnt + 8'd1;
        default: begin
          state <= IDLE;
          gnt <= 2'd3;
        end
      endcase
    end
  end
  assign bus.done = done;
  assign bus.err = done & {N_REQ{abort}};
  assign bus.result = result;
  assign bus.busy = state == LOAD || state == WAIT;
  assign bus.gnt_id = gnt;
  assign bus.m_ld = state == LOAD;
  assign bus.m_a = a;
  assign bus.m_b = b;
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: N_REQ, 3, number of requesters (fixed at 3 for this revision).
REQ-002 Parameter: TIMEOUT, 64, maximum WAIT cycles before an operation is aborted (range 2..255).
REQ-003 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-requester request level; bit i = requester i.
REQ-006 op_a  input  24  operand A, requester i on bits [8i+7:8i].
REQ-007 op_b  input  24  operand B, requester i on bits [8i+7:8i].
REQ-008 done  output  3  one-cycle completion pulse, bit i = requester i.
REQ-009 err  output  3  one-cycle timeout flag, coincident with the matching done bit.
REQ-010 result  output  16  product, valid only in the cycle a done bit is high.
REQ-011 busy  output  1  high while in LOAD or WAIT.
REQ-012 gnt_id  output  2  index of the granted requester; 2'd3 when idle.
REQ-013 m_ld  output  1  one-cycle load strobe to the shared 8x8 multiplier.
REQ-014 m_a, m_b  output  8 each  operands to the multiplier, held stable from LOAD to the end of WAIT.
REQ-015 m_rdy  input  1  multiplier result-ready.
REQ-016 m_result  input  16  multiplier product.

Function
REQ-017 FSM states: IDLE, LOAD, WAIT, DONE; each state change takes one clk cycle.
REQ-018 IDLE: if any req bit is high, select a winner by round-robin starting at ptr, latch its operands into m_a/m_b, set gnt_id, go to LOAD; otherwise stay in IDLE.
REQ-019 Round-robin: ptr resets to 0; after each grant, ptr = (winner+1) mod 3; search order is ptr, ptr+1, ptr+2 (mod 3).
REQ-020 LOAD: m_ld=1 for exactly this cycle; clear the timeout counter; go to WAIT.
REQ-021 WAIT: m_rdy sampled high -> capture m_result into result, go to DONE; otherwise increment the 8-bit counter.
REQ-022 WAIT timeout: when the counter reaches TIMEOUT-1 without m_rdy -> result=16'h0000, set the abort flag, go to DONE.
REQ-023 DONE: done[gnt_id]=1 and err[gnt_id]=abort flag for this one cycle; go to IDLE; gnt_id returns to 3.
REQ-024 If req[gnt_id] is low on entry to DONE (requester withdrew mid-operation), no done/err pulse is generated; result is still updated; the state goes to IDLE.
REQ-025 m_rdy is ignored in IDLE, LOAD and DONE.
REQ-026 Operand changes on op_a/op_b after the grant have no effect on m_a/m_b.
REQ-027 Latency: req rises in IDLE at cycle 0 -> LOAD at cycle 1 (m_ld=1) -> m_rdy at cycle k (k>=2) -> done at cycle k+1.
REQ-028 Requester protocol: hold req high until done; a req still high in the cycle after done is a new request; IDLE is re-entered after DONE, so back-to-back grants are spaced at least 4 cycles.
REQ-029 Simultaneous new requests during LOAD/WAIT/DONE are held pending (req level) and arbitrated only in IDLE.
REQ-030 Products are unsigned 8x8 -> 16 bits; the block performs no arithmetic on data.

Reset
REQ-031 reset high in any state -> next cycle: state IDLE, ptr=0, counter=0, abort=0, done=0, err=0, result=0, busy=0, gnt_id=3, m_ld=0, m_a=0, m_b=0.
REQ-032 Reset during WAIT aborts the operation silently; no done/err pulse; a later m_rdy is ignored.
REQ-033 reset has priority over every other input in the same cycle.

Verification
REQ-034 Single request: req=3'b001, a0=8'd200, b0=8'd3, m_rdy 3 cycles after m_ld -> done=3'b001, result=16'd600, err=0, done 4 cycles after m_ld.
REQ-035 Contention: req=3'b111 held, each requester drops after its own done -> grant order 0,1,2; ptr=0 afterwards; exactly one m_ld per grant.
REQ-036 Fairness: req=3'b011 held continuously -> grants alternate 0,1,0,1; requester 1 is never skipped.
REQ-037 Timeout: m_rdy tied low, TIMEOUT=64 -> done and err for the granted requester 64 cycles after entering WAIT, result=0.
REQ-038 Withdrawal: req[1] drops during WAIT, then m_rdy -> no done pulse, return to IDLE, next pending requester granted.
REQ-039 Reset mid-WAIT: reset pulse, then m_rdy -> all outputs at reset values, no done, gnt_id=3.
